// File: rtl/bsg_wormhole_router_adapter_in_buffered.sv
// Wormhole ingress adapter: buffers whole packets and serialises
// each one into len+1 flits with a tail flag and sticky length error.
module bsg_wormhole_router_adapter_in_buffered #(
  parameter int flit_width_p        = 8,
  parameter int cord_width_p        = 1,
  parameter int len_width_p         = 1,
  parameter int max_payload_width_p = 32,
  parameter int buffer_els_p        = 2,
  localparam int packet_width_lp =
    cord_width_p + len_width_p + max_payload_width_p,
  localparam int max_num_flits_lp =
    (packet_width_lp + flit_width_p - 1) / flit_width_p,
  localparam int link_width_lp = flit_width_p + 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [packet_width_lp-1:0] packet_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [link_width_lp-1:0]   link_o,
  input  logic [link_width_lp-1:0]   link_i,
  output logic                       tail_o,
  output logic                       len_error_o
);

  localparam int cnt_width_lp =
    (max_num_flits_lp > 1) ? $clog2(max_num_flits_lp) : 1;
  localparam int slots_lp   = 1 << cnt_width_lp;
  localparam int max_len_lp = max_num_flits_lp - 1;

  typedef struct packed {
    logic [packet_width_lp-1:0] pkt;
    logic [cnt_width_lp-1:0]    len;
  } entry_t;

  entry_t mem_q [buffer_els_p];
  entry_t mem_d [buffer_els_p];

  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              occ_q, occ_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    len_error_q, len_error_d;

  logic                    full, enq, deq;
  logic                    link_v, link_rdy, flit_yumi, tail;
  logic                    len_over;
  logic [31:0]             len_ext;
  logic [cnt_width_lp-1:0] len_eff;
  logic [31:0]             shamt;
  logic [flit_width_p-1:0] flit_data;
  logic [slots_lp*flit_width_p-1:0] padded;
  entry_t                  head;
  logic                    unused_link;

  function automatic logic next_ptr(input logic p);
    return (buffer_els_p == 2) ? ~p : 1'b0;
  endfunction

  assign full      = (occ_q == 2'(buffer_els_p));
  assign ready_o   = ~full & ~reset_i;
  assign enq       = v_i & ready_o;
  assign link_v    = (occ_q != 2'd0);
  assign link_rdy  = link_i[flit_width_p];
  assign head      = mem_q[rd_ptr_q];
  assign tail      = link_v & (count_q == head.len);
  assign flit_yumi = link_v & link_rdy;
  assign deq       = flit_yumi & tail;

  // Over-length headers are clamped so the serialiser never runs off the end
  assign len_ext  = 32'(packet_i[cord_width_p +: len_width_p]);
  assign len_over = len_ext > 32'(max_len_lp);
  assign len_eff  = len_over ? cnt_width_lp'(max_len_lp)
                             : cnt_width_lp'(len_ext);

  always_comb begin
    padded = '0;
    padded[packet_width_lp-1:0] = head.pkt;
  end

  assign shamt     = 32'(count_q) * 32'(flit_width_p);
  assign flit_data = flit_width_p'(padded >> shamt);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    count_d     = count_q;
    len_error_d = len_error_q;
    if (enq) begin
      mem_d[wr_ptr_q] = '{pkt: packet_i, len: len_eff};
      wr_ptr_d = next_ptr(wr_ptr_q);
      if (len_over) len_error_d = 1'b1;
    end
    if (flit_yumi) begin
      count_d = tail ? '0 : count_q + 1'b1;
    end
    if (deq) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({enq, deq})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      count_q     <= '0;
      len_error_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      count_q     <= count_d;
      len_error_q <= len_error_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign link_o      = {link_v, 1'b0, flit_data};
  assign tail_o      = tail;
  assign len_error_o = len_error_q;

  assign unused_link =
    ^{link_i[link_width_lp-1], link_i[flit_width_p-1:0]};

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_in_buffered.sv
// Bench for the buffered wormhole ingress adapter: three configurations,
// scoreboarded flit checks plus cycle-exact corner-case sequences.
module tb_bsg_wormhole_router_adapter_in_buffered;

  typedef struct {
    logic [7:0] d;
    logic       t;
  } flit_t;

  typedef struct {
    logic [33:0] pkt;
    int          n;
  } vec_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        rst_a, rst_b, rst_c;
  logic [33:0] pa, pc;
  logic [31:0] pb;
  logic        va, vb, vc;
  logic        ra, rb, rc;
  logic [9:0]  lao, lai, lbo, lbi, lco, lci;
  logic        ta, tbt, tc;
  logic        ea, eb, ec;

  flit_t qa[$], qb[$], qc[$];
  int    ca[$], cb[$], cc[$];
  flit_t fa, fb, fc;
  logic       a_hold = 1'b0;
  logic [9:0] a_prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_wormhole_router_adapter_in_buffered u_a (
    .clk_i(clk), .reset_i(rst_a), .packet_i(pa), .v_i(va),
    .ready_o(ra), .link_o(lao), .link_i(lai), .tail_o(ta),
    .len_error_o(ea)
  );

  bsg_wormhole_router_adapter_in_buffered #(
    .len_width_p(3), .max_payload_width_p(28)
  ) u_b (
    .clk_i(clk), .reset_i(rst_b), .packet_i(pb), .v_i(vb),
    .ready_o(rb), .link_o(lbo), .link_i(lbi), .tail_o(tbt),
    .len_error_o(eb)
  );

  bsg_wormhole_router_adapter_in_buffered #(
    .buffer_els_p(1)
  ) u_c (
    .clk_i(clk), .reset_i(rst_c), .packet_i(pc), .v_i(vc),
    .ready_o(rc), .link_o(lco), .link_i(lci), .tail_o(tc),
    .len_error_o(ec)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_a) begin
      a_hold = 1'b0;
    end else begin
      if (lao[9] && lai[8]) begin
        if (qa.size() == 0) chk("a_extra_flit", 1, 0);
        else begin
          fa = qa.pop_front();
          chk("a_data", lao[7:0], fa.d);
          chk("a_tail", ta, fa.t);
        end
        ca.push_back(cyc);
      end
      if (!lao[9]) chk("a_tail_idle", ta, 0);
      chk("a_link_rdy_bit", lao[8], 0);
      if (a_hold) chk("a_stall_hold", {ta, lao[9], lao[7:0]}, a_prev);
      a_hold = lao[9] && !lai[8];
      a_prev = {ta, lao[9], lao[7:0]};
    end
  end

  always @(negedge clk) begin
    if (!rst_b && lbo[9] && lbi[8]) begin
      if (qb.size() == 0) chk("b_extra_flit", 1, 0);
      else begin
        fb = qb.pop_front();
        chk("b_data", lbo[7:0], fb.d);
        chk("b_tail", tbt, fb.t);
      end
      cb.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!rst_c && lco[9] && lci[8]) begin
      if (qc.size() == 0) chk("c_extra_flit", 1, 0);
      else begin
        fc = qc.pop_front();
        chk("c_data", lco[7:0], fc.d);
        chk("c_tail", tc, fc.t);
      end
      cc.push_back(cyc);
    end
  end

  // Offer p to instance w until accepted; push its n expected flits.
  task automatic send(input int w, input logic [33:0] p, input int n,
                      output int acc);
    logic  ok;
    flit_t f;
    ok  = 1'b0;
    acc = -1;
    if (w == 0) begin pa = p; va = 1'b1; end
    else if (w == 1) begin pb = p[31:0]; vb = 1'b1; end
    else begin pc = p; vc = 1'b1; end
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok  = (w == 0) ? ra : (w == 1) ? rb : rc;
      acc = cyc;
      @(posedge clk);
      #1;
    end
    if (w == 0) va = 1'b0;
    else if (w == 1) vb = 1'b0;
    else vc = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      for (int i = 0; i < n; i++) begin
        f.d = 8'(p >> (8 * i));
        f.t = (i == n - 1);
        if (w == 0) qa.push_back(f);
        else if (w == 1) qb.push_back(f);
        else qc.push_back(f);
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 &&
         (qa.size() + qb.size() + qc.size()) != 0; k++)
      @(posedge clk);
    chk("drain_empty", qa.size() + qb.size() + qc.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   acc, acc2, total;

    tbl[0] = '{34'h3_12345678, 1};
    tbl[1] = '{34'h1_CAFEF00E, 2};
    tbl[2] = '{34'h0_000055AA, 2};
    tbl[3] = '{34'h2_87654301, 1};
    tbl[4] = '{34'h3_FFFFFFFF, 2};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    pa = '0; pb = '0; pc = '0;
    lai = 10'h25A; lbi = 10'h25A; lci = 10'h25A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", ra, 0);
    chk("rst_a_valid", lao[9], 0);
    chk("rst_a_rdy_bit", lao[8], 0);
    chk("rst_a_tail", ta, 0);
    chk("rst_a_lerr", ea, 0);
    chk("rst_b_ready", rb, 0);
    chk("rst_b_valid", lbo[9], 0);
    chk("rst_c_ready", rc, 0);
    chk("rst_c_valid", lco[9], 0);
    @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    chk("post_rst_a_ready", ra, 1);
    chk("post_rst_b_ready", rb, 1);
    chk("post_rst_c_ready", rc, 1);
    chk("post_rst_a_valid", lao[9], 0);
    chk("post_rst_c_lerr", ec, 0);
    @(posedge clk);
    #1;
    lai[8] = 1'b1; lbi[8] = 1'b1; lci[8] = 1'b1;

    // Two-flit packet, latency and consecutive flits
    ca.delete();
    send(0, 34'h2_DEADBEEF, 2, acc);
    drain();
    chk("t1_nflits", ca.size(), 2);
    chk("t1_lat0", ca[0], acc + 1);
    chk("t1_lat1", ca[1], acc + 2);
    @(negedge clk);
    chk("t1_idle_valid", lao[9], 0);
    @(posedge clk);
    #1;

    // Back-to-back single-flit packets
    ca.delete();
    send(0, 34'h0_00000011, 1, acc);
    send(0, 34'h0_00000021, 1, acc2);
    chk("t2_b2b_accept", acc2, acc + 1);
    drain();
    chk("t2_nflits", ca.size(), 2);
    chk("t2_flit0_cyc", ca[0], acc + 1);
    chk("t2_flit1_cyc", ca[1], acc + 2);

    // Table stream: no bubble across packet boundaries
    ca.delete();
    total = 0;
    for (int i = 0; i < 5; i++) begin
      send(0, tbl[i].pkt, tbl[i].n, acc);
      total += tbl[i].n;
    end
    drain();
    chk("tbl_nflits", ca.size(), total);
    chk("tbl_no_bubble", ca[ca.size() - 1] - ca[0], total - 1);

    // Backpressure with full buffer
    lai[8] = 1'b0;
    ca.delete();
    send(0, 34'h1_01020306, 2, acc);
    send(0, 34'h0_0000AB13, 2, acc2);
    pa = 34'h0_00000040;
    va = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", ra, 0);
      chk("bp_valid", lao[9], 1);
      chk("bp_data", lao[7:0], 8'h06);
      chk("bp_tail", ta, 0);
      @(posedge clk);
      #1;
    end
    lai[8] = 1'b1;
    send(0, 34'h0_00000040, 1, acc);
    drain();
    chk("bp_nflits", ca.size(), 5);

    // Over-length header clamps and sets sticky error
    send(1, 34'h0_00007753, 2, acc);
    drain();
    @(negedge clk);
    chk("lerr_legal", eb, 0);
    @(posedge clk);
    #1;
    cb.delete();
    send(1, 34'h0_A1B2C3DE, 4, acc);
    @(negedge clk);
    chk("lerr_set", eb, 1);
    drain();
    chk("lerr_nflits", cb.size(), 4);
    @(negedge clk);
    chk("lerr_sticky", eb, 1);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("lerr_cleared", eb, 0);
    chk("lerr_rst_ready", rb, 1);
    @(posedge clk);
    #1;

    // Reset while flit 1 is presented
    send(0, 34'h2_DEADBEEF, 2, acc);
    @(posedge clk);
    #1;
    lai[8] = 1'b0;
    @(negedge clk);
    chk("mid_data", lao[7:0], 8'hBE);
    chk("mid_tail", ta, 1);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    qa.delete();
    @(negedge clk);
    chk("mid_rst_ready", ra, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_valid", lao[9], 0);
    chk("mid_rst_ready2", ra, 0);
    chk("mid_rst_tail", ta, 0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("mid_post_ready", ra, 1);
    chk("mid_post_valid", lao[9], 0);
    @(posedge clk);
    #1;
    lai[8] = 1'b1;
    ca.delete();
    send(0, 34'h1_00000A5E, 2, acc);
    drain();
    chk("mid_new_nflits", ca.size(), 2);
    chk("mid_new_lat", ca[0], acc + 1);

    // Single-entry buffer cadence
    cc.delete();
    send(2, 34'h0_00000011, 1, acc);
    send(2, 34'h0_00000021, 1, acc2);
    drain();
    chk("c_nflits", cc.size(), 2);
    chk("c_second_accept", acc2, cc[0] + 1);
    chk("c_second_flit", cc[1], cc[0] + 2);
    chk("a_lerr_final", ea, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_wormhole_router_adapter_in_buffered.md
# bsg_wormhole_router_adapter_in_buffered

Parametrised wormhole ingress adapter. It accepts whole packets of the form {payload, len, cord} through a valid/ready interface and buffers up to `buffer_els_p` of them. It serialises each packet into `len+1` flits on a wormhole link. Relative to the fixed-width adapter, it adds:
- configurable widths and buffer depth;
- back-to-back packets with no bubble;
- an explicit tail-flit indicator;
- a sticky length-error flag for over-length headers.

## Interface
Parameters:
- `flit_width_p`, 8, link data width.
- `cord_width_p`, 1, width of the destination coordinate field at `packet_i[cord_width_p-1:0]`.
- `len_width_p`, 1, width of the length field at `packet_i[cord_width_p +: len_width_p]`. Value is number of flits minus 1.
- `max_payload_width_p`, 32, payload width, above the len field.
- `buffer_els_p`, 2, packet buffer depth; legal values 1 or 2.
- Derived: `packet_width_lp = cord_width_p + len_width_p + max_payload_width_p`.
- Derived: `max_num_flits_lp = ceil(packet_width_lp / flit_width_p)`.
- Derived: `link_width_lp = flit_width_p + 2`.

Ports:
- `clk_i`  in  1  single clock; all state on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `packet_i`  in  packet_width_lp  packet to send.
- `v_i`  in  1  packet valid.
- `ready_o`  out  1  buffer can accept a packet; a transfer occurs when `v_i & ready_o`.
- `link_o`  out  link_width_lp  output link, packed {v, ready_and, data}:
  - `[flit_width_p+1]` is flit valid.
  - `[flit_width_p]` is tied 0 (this adapter never receives).
  - `[flit_width_p-1:0]` is flit data.
- `link_i`  in  link_width_lp  only `[flit_width_p]` (downstream ready_and) is used; other bits are ignored.
- `tail_o`  out  1  current output flit is the last of its packet; meaningful when link valid is 1.
- `len_error_o`  out  1  sticky: some accepted packet had len > max_num_flits_lp-1.

## Operation
- Buffer: FIFO of `buffer_els_p` entries, each holding {packet, clamped len}.
  - `ready_o = ~full_r & ~reset_i`. It is registered-state based and never depends on `v_i`.
- Length clamp at enqueue: `len_eff = min(len, max_num_flits_lp-1)`.
  - If `len > max_num_flits_lp-1`, set `len_error_o` on the following cycle.
  - `len_error_o` clears only on reset.
- Serialiser counter `count_r`, width `clog2(max_num_flits_lp)` (minimum 1).
  - Flit data is `packet[count_r*flit_width_p +: flit_width_p]`. Bits beyond `packet_width_lp` read as 0.
- Link valid = FIFO non-empty.
- Flit handshake: `flit_yumi = link valid & link_i[flit_width_p]`.
- `tail_o = (count_r == len_eff)` of the head entry.
- On `flit_yumi & ~tail_o`: `count_r` increments.
- On `flit_yumi & tail_o`: `count_r` returns to 0 and the head entry dequeues. If a second entry is present, its flit 0 is presented the next cycle with no idle cycle.
- Simultaneous enqueue and tail-dequeue:
  - When full, `ready_o` is still 0 that cycle. No bypass.
  - When one entry is occupied, both occur; occupancy stays 1.
- Data is never presented from a packet not yet registered. Input-to-link is never combinational.
- Reset mid-packet: the in-flight packet is discarded and the buffer is emptied. Partial wormholes downstream are the system's responsibility.

## Timing
- Reset values:
  - `link_o` valid = 0.
  - `link_o` data undefined but must not be X-gated on valid.
  - `link_o[flit_width_p]` = 0.
  - `tail_o` = 0 (forced low while empty).
  - `ready_o` = 0 during reset, 1 from the first cycle after reset.
  - `count_r` = 0; `len_error_o` = 0.
- Latency: a packet accepted at cycle t presents flit 0 at t+1 at the earliest.
- Throughput:
  - `buffer_els_p=2` sustains 1 flit/cycle across packet boundaries when downstream is always ready.
  - `buffer_els_p=1`: `ready_o` rises the cycle after the tail flit, so flit 0 of the next packet appears 2 cycles after that tail.
- Backpressure: when link ready is 0, data, valid, `tail_o` and `count_r` hold stable.

## Test plan
- Defaults, packet `34'h2_DEADBEEF` (len bit = 1), link ready held 1 -> two flits `8'hEF`, `8'hBE` on consecutive cycles starting 1 cycle after accept. `tail_o` = 0 then 1; valid drops after.
- Defaults, len=0 packets `34'h0_00000011` and `34'h0_00000021` presented back-to-back, ready=1 -> flits `8'h11` and `8'h21` on consecutive cycles, each with `tail_o`=1. `ready_o` never drops below sustained rate.
- Defaults, link ready=0 for 5 cycles mid-packet -> `link_o` frozen on flit 0. Third packet sees `ready_o`=0 once 2 buffered. Resumes in order when ready returns.
- `len_width_p=3`, `max_payload_width_p=28` (max_num_flits=4), len=7 -> exactly 4 flits, `tail_o` on the 4th. `len_error_o`=1 from the cycle after accept and stays set until reset.
- Assert reset during flit 1 of a 2-flit packet -> next cycle: valid=0, `ready_o`=0. After deassert: `ready_o`=1, `count_r`=0. A new packet serialises from flit 0.
- `buffer_els_p=1`, two len=0 packets offered continuously -> second accept exactly one cycle after first tail transfer; its flit appears 2 cycles after the first tail.
